// File: rtl/sequence_generator.sv
// ---------------------------------------------------------------------------
// sequence_generator
//   Serial pattern transmitter. It captures a parallel pattern of
//   programmable length and shifts it out MSB-first on `w`, one bit per
//   clock. The pattern is sent repeat_n+1 times, back to back.
//
//   Optional feature (compile-time macro SEQUENCE_GENERATOR_PARITY_EN):
//   after the data bits of every pass, one even-parity bit is appended.
//
// Parameters
//   PAT_W    maximum pattern length in bits
//   LEN_W    width of len (2**LEN_W must exceed PAT_W)
//   CNT_W    width of repeat_n
//
// Ports
//   clk       rising-edge clock
//   reset     synchronous, active-low reset
//   start     transmission request, sampled only while ready
//   pattern   bits to send; only pattern[len-1:0] is used
//   len       pattern length, clamped to PAT_W
//   repeat_n  extra repetitions (total passes = repeat_n + 1)
//   w         registered serial output, 0 outside SHIFT
//   busy      high while bits are being shifted
//   done      one-cycle pulse after the last bit
//   ready     high in IDLE
// ---------------------------------------------------------------------------
module sequence_generator #(
    parameter int PAT_W = 8,
    parameter int LEN_W = 4,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] len,
    input  logic [CNT_W-1:0] repeat_n,
    output logic             w,
    output logic             busy,
    output logic             done,
    output logic             ready
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PAT_W);

    state_t           state;
    logic [PAT_W-1:0] pat_q;     // captured pattern, first bit at MSB
    logic [PAT_W-1:0] sh_q;      // working shift register for current pass
    logic [LEN_W-1:0] len_q;     // captured, clamped length
    logic [LEN_W-1:0] bit_idx;   // index of the data bit currently on w
    logic [CNT_W-1:0] pass_cnt;  // passes still to send after this one

    logic [LEN_W-1:0] len_c;
    logic [PAT_W-1:0] pat_al;

    assign len_c = (len > LEN_MAX) ? LEN_MAX : len;

    // Left-align the used bits so the first bit to send sits at the MSB;
    // shifting left then walks bit_idx from len-1 down to 0 without any
    // variable bit select on the datapath.
    assign pat_al = pattern << (PAT_W - int'(len_c));

`ifdef SEQUENCE_GENERATOR_PARITY_EN
    logic par_q;      // even parity of the captured data bits
    logic par_phase;  // parity bit of the current pass is on w
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            pat_q    <= '0;
            sh_q     <= '0;
            len_q    <= '0;
            bit_idx  <= '0;
            pass_cnt <= '0;
            w        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            ready    <= 1'b1;
`ifdef SEQUENCE_GENERATOR_PARITY_EN
            par_q     <= 1'b0;
            par_phase <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        pat_q    <= pat_al;
                        sh_q     <= pat_al;
                        len_q    <= len_c;
                        pass_cnt <= repeat_n;
                        ready    <= 1'b0;
`ifdef SEQUENCE_GENERATOR_PARITY_EN
                        // Bits above len were shifted out of pat_al, so
                        // reducing it gives the parity of the used bits.
                        par_q     <= ^pat_al;
                        par_phase <= 1'b0;
`endif
                        if (len_c == '0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= SHIFT;
                            busy    <= 1'b1;
                            w       <= pat_al[PAT_W-1];
                            bit_idx <= len_c - 1'b1;
                        end
                    end
                end

                SHIFT: begin
                    if (bit_idx != '0) begin
                        bit_idx <= bit_idx - 1'b1;
                        sh_q    <= {sh_q[PAT_W-2:0], 1'b0};
                        w       <= sh_q[PAT_W-2];
                    end
`ifdef SEQUENCE_GENERATOR_PARITY_EN
                    else if (!par_phase) begin
                        par_phase <= 1'b1;
                        w         <= par_q;
                    end
`endif
                    else if (pass_cnt != '0) begin
                        // Next pass starts on the very next cycle.
                        pass_cnt <= pass_cnt - 1'b1;
                        bit_idx  <= len_q - 1'b1;
                        sh_q     <= pat_q;
                        w        <= pat_q[PAT_W-1];
`ifdef SEQUENCE_GENERATOR_PARITY_EN
                        par_phase <= 1'b0;
`endif
                    end else begin
                        state <= DONE;
                        w     <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`ifdef SEQUENCE_GENERATOR_PARITY_EN
                        par_phase <= 1'b0;
`endif
                    end
                end

                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                    w     <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule
